// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode/issue stage feeding the ID/EX pipeline register with bypass, load-use interlock and flush.
module id_ex_stage #(
    parameter bit BYPASS_EN = 1'b1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [4:0]  ex_opcode,
    output logic [2:0]  ex_func3,
    output logic [6:0]  ex_func7,
    output logic [31:0] ex_operand1,
    output logic [31:0] ex_operand2,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_we,
    output logic        ex_illegal
);
    localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LD = 5'b00000, OP_ST = 5'b01000,
                           OP_BR = 5'b11000, OP_AUIPC = 5'b00101, OP_LUI = 5'b01101,
                           OP_JAL = 5'b11011, OP_JALR = 5'b11001;
    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } ex_t;
    ex_t         ex_q, ex_d, dec;
    logic        valid_q, valid_d;
    logic [4:0]  opc, rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
    logic        legal, wr, use1, use2, hazard, accept;
    assign opc = if_instr[6:2];
    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign rd  = if_instr[11:7];
    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;
    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    // x0 is hard zero, so the bypass compare needs no separate wb_rd != 0 term
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : (BYPASS_EN && wb_we && wb_rd == rs1) ? wb_data : rf_rs1_data;
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : (BYPASS_EN && wb_we && wb_rd == rs2) ? wb_data : rf_rs2_data;
    always_comb begin
        dec = '0;
        legal = 1'b1;
        wr = 1'b0;
        use1 = 1'b0;
        use2 = 1'b0;
        dec.opcode = opc;
        dec.func3 = if_instr[14:12];
        dec.func7 = if_instr[31:25];
        dec.pc = if_pc;
        dec.rd = rd;
        dec.rs2_data = rs2_val;
        dec.imm = imm_i;
        case (opc)
            OP_R:         begin dec.op1 = rs1_val; dec.op2 = rs2_val; wr = 1'b1; use1 = 1'b1; use2 = 1'b1; end
            OP_I, OP_LD:  begin dec.op1 = rs1_val; dec.op2 = imm_i; wr = 1'b1; use1 = 1'b1; end
            OP_ST:        begin dec.op1 = rs1_val; dec.op2 = imm_s; dec.imm = imm_s; use1 = 1'b1; use2 = 1'b1; end
            OP_BR:        begin dec.op1 = rs1_val; dec.op2 = rs2_val; dec.imm = imm_b; use1 = 1'b1; use2 = 1'b1; end
            OP_AUIPC:     begin dec.op1 = if_pc; dec.op2 = imm_u; dec.imm = imm_u; wr = 1'b1; end
            OP_LUI:       begin dec.op2 = imm_u; dec.imm = imm_u; wr = 1'b1; end
            OP_JAL:       begin dec.op1 = if_pc; dec.op2 = imm_j; dec.imm = imm_j; wr = 1'b1; end
            OP_JALR:      begin dec.op1 = if_pc; dec.op2 = rs1_val; wr = 1'b1; use1 = 1'b1; end
            default:      legal = 1'b0;
        endcase
        if (if_instr[1:0] != 2'b11) legal = 1'b0;
        dec.illegal = !legal;
        dec.rd_we = legal && wr && (rd != 5'd0);
        if (!legal) begin
            dec.op1 = '0;
            dec.op2 = '0;
        end
    end
    assign hazard = HAZARD_EN && if_valid && valid_q && ex_q.opcode == OP_LD && ex_q.rd != 5'd0 &&
                    ((use1 && rs1 == ex_q.rd) || (use2 && rs2 == ex_q.rd));
    assign if_ready = !flush && !hazard && (!valid_q || ex_ready);
    assign accept = if_valid && if_ready;
    always_comb begin
        ex_d = ex_q;
        valid_d = valid_q;
        if (flush) valid_d = 1'b0;
        else if (accept) begin
            ex_d = dec;
            valid_d = 1'b1;
        end else if (ex_ready) valid_d = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ex_q <= '0;
        end else begin
            valid_q <= valid_d;
            ex_q <= ex_d;
        end
    end
    assign ex_valid = valid_q;
    assign ex_opcode = ex_q.opcode;
    assign ex_func3 = ex_q.func3;
    assign ex_func7 = ex_q.func7;
    assign ex_operand1 = ex_q.op1;
    assign ex_operand2 = ex_q.op2;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm = ex_q.imm;
    assign ex_pc = ex_q.pc;
    assign ex_rd = ex_q.rd;
    assign ex_rd_we = ex_q.rd_we;
    assign ex_illegal = ex_q.illegal;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/issue stage of the pipelined RV32I core; the producer side of the EX-stage ALU interface.
- Takes a fetched instruction and PC, reads register operands, and builds the immediate.
- Selects operand1/operand2 and registers opcode[6:2], func3, func7 and both operands into the ID/EX pipeline register.
- Uses a valid/ready handshake, WB bypass, load-use interlock and flush.

Parameters:
BYPASS_EN, 1, 1 = forward WB write data onto same-cycle register reads; 0 = raw register-file data
HAZARD_EN, 1, 1 = enable load-use interlock against the instruction held in the ID/EX register

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  stage accepts the instruction this cycle
if_instr  in  32  instruction word
if_pc  in  32  PC of if_instr
rf_rs1_addr  out  5  combinational, = if_instr[19:15]
rf_rs2_addr  out  5  combinational, = if_instr[24:20]
rf_rs1_data  in  32  register file read data 1 (same cycle)
rf_rs2_data  in  32  register file read data 2 (same cycle)
wb_we  in  1  writeback write enable
wb_rd  in  5  writeback destination
wb_data  in  32  writeback data
flush  in  1  kill the incoming instruction and the held instruction (branch/jump taken)
ex_ready  in  1  EX consumes the held instruction this cycle
ex_valid  out  1  ID/EX register holds a valid instruction
ex_opcode  out  5  instr[6:2]
ex_func3  out  3  instr[14:12]
ex_func7  out  7  instr[31:25]
ex_operand1  out  32  ALU operand 1
ex_operand2  out  32  ALU operand 2
ex_rs2_data  out  32  store data (bypassed rs2)
ex_imm  out  32  sign-extended immediate, for branch/JAL/JALR targets
ex_pc  out  32  PC of the held instruction
ex_rd  out  5  destination register
ex_rd_we  out  1  writes rd (forced 0 when rd == 0)
ex_illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst_n low, async): every ex_* output = 0; ex_valid = 0. if_ready is combinational.
- Latency: one cycle. An instruction accepted at edge N appears on ex_* after edge N.
- Acceptance: accept = if_valid && if_ready.
- if_ready = !flush && !hazard && (!ex_valid || ex_ready).
- Register update, in priority order:
  - flush: ex_valid <= 0.
  - else accept: load all fields, ex_valid <= 1.
  - else ex_ready: ex_valid <= 0 (bubble).
  - else hold all fields.
- While ex_valid && !ex_ready, all ex_* stay stable.
- Immediates:
  - I = instr[31:20]
  - S = {[31:25],[11:7]}
  - B = {[31],[7],[30:25],[11:8],0}
  - U = {[31:12],12'b0}
  - J = {[31],[19:12],[20],[30:21],0}
  - All are sign-extended to 32 bits.
- Operand select by opcode[6:2]:
  - 01100 R: op1 = rs1, op2 = rs2.
  - 00100 I-ALU: op1 = rs1, op2 = I-imm. Shifts use imm[4:0]; func7 is passed raw so srai is distinguishable.
  - 00000 load: op1 = rs1, op2 = I-imm.
  - 01000 store: op1 = rs1, op2 = S-imm, ex_rs2_data = rs2.
  - 11000 branch: op1 = rs1, op2 = rs2, imm = B-imm.
  - 00101 AUIPC: op1 = pc, op2 = U-imm.
  - 01101 LUI: op1 = 0, op2 = U-imm.
  - 11011 JAL: op1 = pc, op2 = J-imm, imm = J-imm.
  - 11001 JALR: op1 = pc, op2 = rs1, imm = I-imm.
  - Any other opcode, or instr[1:0] != 11: ex_illegal = 1, ex_rd_we = 0, operands = 0.
- rd write: ex_rd_we = 1 for R, I-ALU, load, AUIPC, LUI, JAL, JALR with rd != 0; otherwise 0.
- Bypass (BYPASS_EN = 1): for each source, if wb_we && wb_rd != 0 && wb_rd == source address, use wb_data, else rf data. x0 always reads as 0.
- Hazard (HAZARD_EN = 1): hazard = if_valid && ex_valid && held opcode == 00000 && ex_rd != 0 && incoming instruction uses rs1 or rs2 (per type) and that source == ex_rd.
  - U/J types use no sources; I/load/JALR use rs1 only.
  - While hazard holds, the incoming instruction is not accepted; once EX takes the load, a bubble is inserted.
- Flush together with accept: flush wins and the incoming instruction is dropped.
- Reset mid-operation: held instruction lost, ex_valid = 0 immediately.

Test Plan:
1. Reset, then add x3,x1,x2 (0x002081B3) with x1 = 5, x2 = 7 and ex_ready = 1 -> next cycle ex_valid = 1, opcode 01100, func3 000, op1 = 5, op2 = 7, rd = 3, rd_we = 1.
2. addi x1,x0,-1 (0xFFF00093) -> op2 = 0xFFFFFFFF. jal x1,+8 at pc 0x100 -> op1 = 0x100, imm = 8. lui x5,0x12345 -> op2 = 0x12345000.
3. Same-cycle wb_we = 1, wb_rd = 1, wb_data = 0xAA while decoding add x3,x1,x2 -> op1 = 0xAA. Repeat with wb_rd = 0 and x0 source -> op1 = 0.
4. lw x4,0(x1) held, ex_ready = 1, next instruction add x5,x4,x4 -> if_ready = 0 for one cycle, bubble (ex_valid = 0), then add accepted. Repeat with add x5,x6,x6 -> no stall.
5. ex_ready = 0 for 3 cycles with if_valid = 1 -> if_ready = 0 and ex_* stable. flush = 1 with if_valid = 1 -> ex_valid = 0 next cycle, instruction dropped.
6. Instruction 0x00000000 or opcode 1111111 -> ex_illegal = 1, rd_we = 0. Assert rst_n low mid-stall -> ex_valid = 0 asynchronously.
